limb_sequencer: RTL and testbench

Multi-cycle control unit for the Limb 8-bit CPU. It fetches 32-bit instructions from program ROM and decodes them. It then sequences the register file, ALU, RAM, call stack and RIO port through fixed fetch/decode/execute/writeback states. It owns the PC, the IR, the call-depth counter and the `rio_out` register. It computes branch conditions itself; all arithmetic is delegated to the external ALU.

---
 rtl/limb_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_limb_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/limb_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback controller for the Limb 8-bit CPU.
// Holds pc, IR, call depth and rio_out; arithmetic lives in the external ALU.
module limb_sequencer #(
  parameter int STACK_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic [7:0]  rom_addr,
  input  logic [31:0] rom_data,
  output logic [3:0]  rf_src_a,
  output logic [3:0]  rf_src_b,
  input  logic [7:0]  rf_out_a,
  input  logic [7:0]  rf_out_b,
  output logic [3:0]  rf_dst,
  output logic [7:0]  rf_wdata,
  output logic        rf_we,
  output logic [3:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_out,
  output logic        ram_we,
  output logic [7:0]  ram_addr,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout,
  output logic        stk_push,
  output logic        stk_pop,
  output logic [7:0]  stk_din,
  input  logic [7:0]  stk_dout,
  input  logic [7:0]  rio_in,
  output logic [7:0]  rio_out,
  output logic        halted,
  output logic        fault,
  output logic        retire
);

  localparam int DW = $clog2(STACK_DEPTH + 1);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_RETWAIT,
    S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic [7:0]      rio_q, rio_d;
  logic            halted_q, halted_d;
  logic            fault_q, fault_d;

  logic            imm_a, imm_b;
  logic [1:0]      cls;
  logic [3:0]      func;
  logic [7:0]      fld_a, fld_b, fld_d;
  logic            is_alu, is_br, is_ld, is_st, is_in, is_out;
  logic            is_call, is_ret, is_halt;
  logic [7:0]      op_a, op_b, pc_inc;
  logic            br_taken, stack_full, stack_empty, operands_live;

  assign imm_a  = ir_q[31];
  assign imm_b  = ir_q[30];
  assign cls    = ir_q[29:28];
  assign func   = ir_q[27:24];
  assign fld_a  = ir_q[23:16];
  assign fld_b  = ir_q[15:8];
  assign fld_d  = ir_q[7:0];

  assign is_alu  = (cls == 2'b00);
  assign is_br   = (cls == 2'b01);
  assign is_ld   = (cls == 2'b10) && (func == 4'd0);
  assign is_st   = (cls == 2'b10) && (func == 4'd1);
  assign is_in   = (cls == 2'b10) && (func == 4'd2);
  assign is_out  = (cls == 2'b10) && (func == 4'd3);
  assign is_call = (cls == 2'b11) && (func == 4'd0);
  assign is_ret  = (cls == 2'b11) && (func == 4'd1);
  assign is_halt = (cls == 2'b11) && (func == 4'd2);

  assign op_a        = imm_a ? fld_a : rf_out_a;
  assign op_b        = imm_b ? fld_b : rf_out_b;
  assign pc_inc      = pc_q + 8'd1;
  assign stack_full  = (depth_q == DW'(STACK_DEPTH));
  assign stack_empty = (depth_q == '0);

  // Unsigned comparisons; funcs 7..15 are "never".
  always_comb begin
    br_taken = 1'b0;
    case (func)
      4'd0:    br_taken = (op_a == op_b);
      4'd1:    br_taken = (op_a != op_b);
      4'd2:    br_taken = (op_a <  op_b);
      4'd3:    br_taken = (op_a <= op_b);
      4'd4:    br_taken = (op_a >  op_b);
      4'd5:    br_taken = (op_a >= op_b);
      4'd6:    br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

  // Read addresses come straight from IR so they hold steady from DECODE to FETCH.
  assign rom_addr = pc_q;
  assign rf_src_a = fld_a[3:0];
  assign rf_src_b = (is_ld || is_st) ? 4'hF : fld_b[3:0];
  assign rf_dst   = fld_d[3:0];
  assign alu_op   = func;
  assign rio_out  = rio_q;
  assign halted   = halted_q;
  assign fault    = fault_q;

  assign operands_live = (state_q == S_DECODE) || (state_q == S_EXEC) || (state_q == S_WB);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    depth_d  = depth_q;
    rio_d    = rio_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    rf_we    = 1'b0;
    rf_wdata = 8'd0;
    alu_a    = 8'd0;
    alu_b    = 8'd0;
    ram_we   = 1'b0;
    ram_addr = 8'd0;
    ram_din  = 8'd0;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_din  = 8'd0;
    retire   = 1'b0;

    if (operands_live) begin
      alu_a = op_a;
      alu_b = op_b;
      if (is_ld || is_st) ram_addr = rf_out_b;
      if (is_st)          ram_din  = op_a;
    end

    case (state_q)
      S_FETCH: begin
        if (run) begin
          ir_d    = rom_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_WB;
        if (is_call) begin
          if (stack_full) begin
            fault_d  = 1'b1;
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            stk_push = 1'b1;
            stk_din  = pc_inc;
            depth_d  = depth_q + DW'(1);
          end
        end else if (is_ret) begin
          if (stack_empty) begin
            fault_d  = 1'b1;
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            stk_pop = 1'b1;
            depth_d = depth_q - DW'(1);
            state_d = S_RETWAIT;
          end
        end else if (is_halt) begin
          retire   = 1'b1;
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else if (is_st) begin
          ram_we = 1'b1;
        end else if (is_out) begin
          rio_d = op_a;
        end
      end
      S_WB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
        // Writes to r0 are discarded.
        if ((is_alu || is_ld || is_in) && (fld_d[3:0] != 4'd0)) begin
          rf_we    = 1'b1;
          rf_wdata = is_ld ? ram_dout : (is_in ? rio_in : alu_out);
        end
        if (is_br)        pc_d = br_taken ? fld_d : pc_inc;
        else if (is_call) pc_d = fld_d;
        else              pc_d = pc_inc;
      end
      S_RETWAIT: begin
        retire  = 1'b1;
        pc_d    = stk_dout;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= 8'd0;
      ir_q     <= 32'd0;
      depth_q  <= '0;
      rio_q    <= 8'd0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      depth_q  <= depth_d;
      rio_q    <= rio_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

endmodule

// File: tb/tb_limb_sequencer.sv
// Bench for limb_sequencer: ROM/regfile/RAM/stack/ALU environment, an
// instruction-level reference model compared every cycle, plus literal checks.
module tb_limb_sequencer;

  localparam int SD = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic [3:0]  rf_src_a, rf_src_b, rf_dst, alu_op;
  logic [7:0]  rf_out_a, rf_out_b, rf_wdata, alu_a, alu_b, alu_out;
  logic        rf_we, ram_we, stk_push, stk_pop, halted, fault, retire;
  logic [7:0]  ram_addr, ram_din, ram_dout, stk_din, stk_dout, rio_out;
  logic [7:0]  rio_in;

  always #5 clk = ~clk;
  assign rio_in = 8'h9E;

  limb_sequencer #(.STACK_DEPTH(SD)) dut (
    .clk(clk), .reset(reset), .run(run),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .rf_src_a(rf_src_a), .rf_src_b(rf_src_b),
    .rf_out_a(rf_out_a), .rf_out_b(rf_out_b),
    .rf_dst(rf_dst), .rf_wdata(rf_wdata), .rf_we(rf_we),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din), .stk_dout(stk_dout),
    .rio_in(rio_in), .rio_out(rio_out),
    .halted(halted), .fault(fault), .retire(retire)
  );

  function automatic logic [7:0] init_rf(input int i);
    if (i == 1)  return 8'h07;
    if (i == 15) return 8'h33;
    return 8'(i);
  endfunction

  function automatic logic [7:0] alu_fn(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  function automatic logic cond_fn(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      4'd0:    return a == b;
      4'd1:    return a != b;
      4'd2:    return a < b;
      4'd3:    return a <= b;
      4'd4:    return a > b;
      4'd5:    return a >= b;
      4'd6:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- environment ----------------
  logic [31:0] rom [0:255];
  logic [7:0]  rf  [0:15];
  logic [7:0]  ram [0:255];
  logic [7:0]  stk [0:255];
  logic [8:0]  sp;

  assign rom_data = rom[rom_addr];
  assign rf_out_a = rf[rf_src_a];
  assign rf_out_b = rf[rf_src_b];
  assign ram_dout = ram[ram_addr];
  assign alu_out  = alu_fn(alu_op, alu_a, alu_b);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) rf[i] <= init_rf(i);
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
      sp       <= 9'd0;
      stk_dout <= 8'h00;
    end else begin
      if (rf_we)  rf[rf_dst] <= rf_wdata;
      if (ram_we) ram[ram_addr] <= ram_din;
      if (stk_push) begin
        stk[sp[7:0]] <= stk_din;
        sp <= sp + 9'd1;
      end
      if (stk_pop) begin
        stk_dout <= stk[8'(sp - 9'd1)];
        sp <= sp - 9'd1;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0]  m_pc, m_rio, m_ret;
  logic [31:0] m_ir;
  int          m_ph, m_depth;
  logic        m_halt, m_fault;
  logic [7:0]  m_rf  [0:15];
  logic [7:0]  m_ram [0:255];
  logic [7:0]  m_stk [0:255];

  logic [1:0]  m_cls;
  logic [3:0]  m_fn;
  logic [7:0]  m_opa, m_opb, m_wb, m_npc;
  logic        e_ld, e_st, e_in, e_out, e_call, e_ret, e_halt, e_wr;

  always_comb begin
    m_cls  = m_ir[29:28];
    m_fn   = m_ir[27:24];
    m_opa  = m_ir[31] ? m_ir[23:16] : m_rf[m_ir[19:16]];
    m_opb  = m_ir[30] ? m_ir[15:8]  : m_rf[m_ir[11:8]];
    e_ld   = (m_cls == 2'd2) && (m_fn == 4'd0);
    e_st   = (m_cls == 2'd2) && (m_fn == 4'd1);
    e_in   = (m_cls == 2'd2) && (m_fn == 4'd2);
    e_out  = (m_cls == 2'd2) && (m_fn == 4'd3);
    e_call = (m_cls == 2'd3) && (m_fn == 4'd0);
    e_ret  = (m_cls == 2'd3) && (m_fn == 4'd1);
    e_halt = (m_cls == 2'd3) && (m_fn == 4'd2);
    e_wr   = ((m_cls == 2'd0) || e_ld || e_in) && (m_ir[3:0] != 4'd0);
    m_wb   = e_ld ? m_ram[m_rf[15]] : (e_in ? 8'h9E : alu_fn(m_fn, m_opa, m_opb));
    if (m_cls == 2'd1)  m_npc = cond_fn(m_fn, m_opa, m_opb) ? m_ir[7:0] : m_pc + 8'd1;
    else if (e_call)    m_npc = m_ir[7:0];
    else if (e_ret)     m_npc = m_ret;
    else                m_npc = m_pc + 8'd1;
  end

  // m_ph: 0 fetch, 1 decode, 2 execute, 3 completion (writeback or return).
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc <= 8'd0; m_ir <= 32'd0; m_ph <= 0; m_depth <= 0;
      m_rio <= 8'd0; m_ret <= 8'd0; m_halt <= 1'b0; m_fault <= 1'b0;
      for (int i = 0; i < 16; i++) m_rf[i] <= init_rf(i);
      for (int i = 0; i < 256; i++) m_ram[i] <= 8'h00;
    end else if (!m_halt) begin
      case (m_ph)
        0: if (run) begin m_ir <= rom[m_pc]; m_ph <= 1; end
        1: m_ph <= 2;
        2: begin
          m_ph <= 3;
          if (e_halt) m_halt <= 1'b1;
          else if (e_call) begin
            if (m_depth == SD) begin m_fault <= 1'b1; m_halt <= 1'b1; end
            else begin m_stk[m_depth] <= m_pc + 8'd1; m_depth <= m_depth + 1; end
          end else if (e_ret) begin
            if (m_depth == 0) begin m_fault <= 1'b1; m_halt <= 1'b1; end
            else begin m_ret <= m_stk[m_depth - 1]; m_depth <= m_depth - 1; end
          end else if (e_st) m_ram[m_rf[15]] <= m_opa;
          else if (e_out) m_rio <= m_opa;
        end
        default: begin
          if (e_wr) m_rf[m_ir[3:0]] <= m_wb;
          m_pc <= m_npc;
          m_ph <= 0;
        end
      endcase
    end
  end

  // ---------------- checking ----------------
  int vectors = 0;
  int miscompares = 0;
  int cnt_push, cnt_pop, cnt_ramwe, cnt_rfwe, cnt_retire;
  int tag = 0;
  int done_tag = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic lit_checks(input int t);
    case (t)
      1: begin
        check("p1_wb_alu_a", alu_a, 8'h05);   check("p1_wb_alu_b", alu_b, 8'h00);
        check("p1_wb_alu_op", alu_op, 4'h0);  check("p1_wb_rf_dst", rf_dst, 4'h3);
        check("p1_wb_rf_we", rf_we, 1'b1);    check("p1_wb_retire", retire, 1'b1);
      end
      5: begin
        check("st_ram_addr", ram_addr, 8'h33); check("st_ram_din", ram_din, 8'hAA);
        check("st_ram_we", ram_we, 1'b1);
      end
      2: check("beq_taken_pc", rom_addr, 8'h40);
      3: check("beq_not_taken_pc", rom_addr, 8'h41);
      4: begin
        check("p1_halted", halted, 1'b1);     check("p1_fault", fault, 1'b0);
        check("out_rio", rio_out, 8'h5C);     check("p1_ramwe_count", cnt_ramwe, 1);
        check("p1_rfwe_count", cnt_rfwe, 4);  check("p1_retire_count", cnt_retire, 10);
        check("r3_alu", rf[3], 8'h05);        check("r4_sub", rf[4], 8'hFE);
        check("r5_load", rf[5], 8'hAA);       check("r6_in", rf[6], 8'h9E);
        check("ram33", ram[8'h33], 8'hAA);
      end
      6: begin check("call_push", stk_push, 1'b1); check("call_din", stk_din, 8'h11); end
      7: check("call_target", rom_addr, 8'h20);
      8: check("ret_pop", stk_pop, 1'b1);
      9: check("ret_target", rom_addr, 8'h11);
      10: begin
        check("ret0_fault", fault, 1'b1);     check("ret0_halted", halted, 1'b1);
        check("p2_retire_count", cnt_retire, 3); check("p2_pop_count", cnt_pop, 1);
        check("ret0_pc_held", rom_addr, 8'h11);
      end
      11: begin
        check("ovf_fault", fault, 1'b1);      check("ovf_halted", halted, 1'b1);
        check("ovf_push_count", cnt_push, 2); check("ovf_pc_held", rom_addr, 8'h02);
      end
      12: begin
        check("idle_rom_addr", rom_addr, 8'h00); check("idle_push", cnt_push, 0);
        check("idle_ramwe", cnt_ramwe, 0);       check("idle_rfwe", cnt_rfwe, 0);
        check("idle_retire", cnt_retire, 0);
      end
      13: begin
        check("rst_rom_addr", rom_addr, 8'h00); check("rst_rf_src_a", rf_src_a, 4'h0);
        check("rst_rf_src_b", rf_src_b, 4'h0);  check("rst_rf_dst", rf_dst, 4'h0);
        check("rst_rf_we", rf_we, 1'b0);        check("rst_rf_wdata", rf_wdata, 8'h00);
        check("rst_alu_op", alu_op, 4'h0);      check("rst_alu_a", alu_a, 8'h00);
        check("rst_alu_b", alu_b, 8'h00);       check("rst_ram_we", ram_we, 1'b0);
        check("rst_ram_addr", ram_addr, 8'h00); check("rst_ram_din", ram_din, 8'h00);
        check("rst_stk_push", stk_push, 1'b0);  check("rst_stk_pop", stk_pop, 1'b0);
        check("rst_stk_din", stk_din, 8'h00);   check("rst_rio_out", rio_out, 8'h00);
        check("rst_halted", halted, 1'b0);      check("rst_fault", fault, 1'b0);
        check("rst_retire", retire, 1'b0);
      end
      14: begin check("wrap_pc", rom_addr, 8'h00); check("wrap_fault", fault, 1'b0); end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (reset) begin
      cnt_push <= 0; cnt_pop <= 0; cnt_ramwe <= 0; cnt_rfwe <= 0; cnt_retire <= 0;
    end else begin
      cnt_push   <= cnt_push + int'(stk_push);
      cnt_pop    <= cnt_pop + int'(stk_pop);
      cnt_ramwe  <= cnt_ramwe + int'(ram_we);
      cnt_rfwe   <= cnt_rfwe + int'(rf_we);
      cnt_retire <= cnt_retire + int'(retire);
      check("rom_addr", rom_addr, m_pc);
      check("rio_out", rio_out, m_rio);
      check("halted", halted, m_halt);
      check("fault", fault, m_fault);
      check("retire", retire, !m_halt && (m_ph == 3 || (m_ph == 2 && e_halt)));
      check("rf_we", rf_we, !m_halt && m_ph == 3 && e_wr);
      check("ram_we", ram_we, !m_halt && m_ph == 2 && e_st);
      check("stk_push", stk_push, !m_halt && m_ph == 2 && e_call && m_depth < SD);
      check("stk_pop", stk_pop, !m_halt && m_ph == 2 && e_ret && m_depth > 0);
      if (!m_halt && m_ph == 3 && e_wr) begin
        check("rf_dst", rf_dst, m_ir[3:0]);
        check("rf_wdata", rf_wdata, m_wb);
      end
      if (!m_halt && m_ph == 2 && (e_ld || e_st)) check("ram_addr", ram_addr, m_rf[15]);
      if (!m_halt && m_ph == 2 && e_st) check("ram_din", ram_din, m_opa);
      if (!m_halt && m_ph == 2 && e_call && m_depth < SD) check("stk_din", stk_din, m_pc + 8'd1);
      if (!m_halt && m_ph >= 2 && m_cls == 2'd0) begin
        check("alu_op", alu_op, m_fn);
        check("alu_a", alu_a, m_opa);
        check("alu_b", alu_b, m_opb);
      end
    end
    if (tag != done_tag) begin
      lit_checks(tag);
      done_tag <= tag;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 32'h3200_0000;
  endtask

  task automatic restart(input logic go);
    reset = 1'b1;
    run   = 1'b0;
    cyc(2);
    reset = 1'b0;
    run   = go;
  endtask

  initial begin
    clear_rom();
    cyc(1);

    // ALU, memory, IO, branches, HALT
    clear_rom();
    rom[0]     = 32'h8005_0003;  // r3 = 5 + r0
    rom[1]     = 32'h0103_0104;  // r4 = r3 - r1
    rom[2]     = 32'hA1AA_0000;  // RAM[r15] = 0xAA
    rom[3]     = 32'h2000_0005;  // r5 = RAM[r15]
    rom[4]     = 32'hA35C_0000;  // rio_out = 0x5C
    rom[5]     = 32'h2200_0000;  // IN to r0: no write
    rom[6]     = 32'h2200_0006;  // r6 = rio_in
    rom[7]     = 32'h5001_0740;  // BEQ r1,#7 -> 0x40
    rom[8'h40] = 32'h5001_0800;  // BEQ r1,#8 not taken
    rom[8'h41] = 32'h3200_0000;  // HALT
    restart(1'b1);
    cyc(3);  tag = 1;
    cyc(7);  tag = 5;
    cyc(22); tag = 2;
    cyc(4);  tag = 3;
    cyc(5);  tag = 4;
    cyc(2);

    // CALL / RET, then RET at depth 0
    clear_rom();
    rom[0]     = 32'h1600_0010;
    rom[8'h10] = 32'h3000_0020;
    rom[8'h20] = 32'h3100_0000;
    rom[8'h11] = 32'h3100_0000;
    restart(1'b1);
    cyc(6); tag = 6;
    cyc(2); tag = 7;
    cyc(2); tag = 8;
    cyc(2); tag = 9;
    cyc(4); tag = 10;
    cyc(2);

    // Nested CALLs overflow a two-entry stack
    clear_rom();
    rom[0] = 32'h3000_0001;
    rom[1] = 32'h3000_0002;
    rom[2] = 32'h3000_0003;
    restart(1'b1);
    cyc(14); tag = 11;
    cyc(2);

    // run low holds everything; reset during EXEC aborts
    clear_rom();
    rom[0] = 32'h8005_0003;
    restart(1'b0);
    cyc(10); tag = 12;
    run = 1'b1;
    cyc(2);
    #2 reset = 1'b1;
    #1 tag = 13;
    cyc(2);

    // pc wraps from 255 to 0
    clear_rom();
    rom[0]   = 32'h1600_00FF;
    rom[255] = 32'h3F00_0000;
    restart(1'b1);
    cyc(8); tag = 14;
    run = 1'b0;
    cyc(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
